// File: rtl/div_fx_engine.sv
// div_fx_engine: sequential 16.8 fixed-point divider attached to a byte-wide data memory.
// Reads a 16-bit dividend D and an 8-bit divisor d, computes q = floor(D*256/d) one bit
// per cycle by restoring division, writes q back MSB first, then raises Ack.
// A zero divisor skips the division and writes q = 24'hFFFFFF.
//
// Configuration macro: DIV_ROUND_EN
//   defined   - 25 iterations, q rounded up on the half-LSB, saturating at 24'hFFFFFF
//   undefined - 24 iterations, truncating quotient
//
// Ports:
//   Clk        in   1   clock, rising edge
//   Reset      in   1   synchronous active-low reset
//   Start      in   1   launch request; a run begins on its falling edge
//   Ack        out  1   done flag, held until the next Start assertion
//   Busy       out  1   high while the FSM is outside IDLE/DONE
//   MemAddr    out  AW  data-memory address
//   MemRdData  in   8   combinational read data for MemAddr
//   MemWrEn    out  1   write strobe, one byte per cycle
//   MemWrData  out  8   write data
module div_fx_engine #(
  parameter int unsigned AW       = 8,
  parameter int unsigned A_DVD_HI = 0,
  parameter int unsigned A_DVD_LO = 1,
  parameter int unsigned A_DVS    = 2,
  parameter int unsigned A_Q      = 4
) (
  input  logic          Clk,
  input  logic          Reset,
  input  logic          Start,
  output logic          Ack,
  output logic          Busy,
  output logic [AW-1:0] MemAddr,
  input  logic [7:0]    MemRdData,
  output logic          MemWrEn,
  output logic [7:0]    MemWrData
);

`ifdef DIV_ROUND_EN
  localparam int unsigned QW = 25;  // extra low bit is the half-LSB
`else
  localparam int unsigned QW = 24;
`endif
  localparam int unsigned NPAD = QW - 16;

  localparam logic [3:0] StIdle  = 4'd0;
  localparam logic [3:0] StRdHi  = 4'd1;
  localparam logic [3:0] StRdLo  = 4'd2;
  localparam logic [3:0] StRdDvs = 4'd3;
  localparam logic [3:0] StDiv   = 4'd4;
  localparam logic [3:0] StWr0   = 4'd5;
  localparam logic [3:0] StWr1   = 4'd6;
  localparam logic [3:0] StWr2   = 4'd7;
  localparam logic [3:0] StDone  = 4'd8;

  logic [3:0]    state_q, state_d;
  logic          armed_q, armed_d;
  logic          ack_q, ack_d;
  logic [15:0]   dvd_q, dvd_d;
  logic [7:0]    dvs_q, dvs_d;
  logic [8:0]    rem_q, rem_d;
  logic [QW-1:0] quo_q, quo_d;
  logic [4:0]    cnt_q, cnt_d;

  logic [QW-1:0] n_vec;
  logic [8:0]    r9;
  logic          q_bit;
  logic [23:0]   res24;
  logic          unused_rem;

  // Numerator N = {D, zero fraction bits}; consumed MSB first by cnt_q.
  assign n_vec      = {dvd_q, {NPAD{1'b0}}};
  assign r9         = {rem_q[7:0], n_vec[cnt_q]};
  assign q_bit      = (r9 >= {1'b0, dvs_q});
  // The remainder never exceeds d-1, so its top bit only holds the r9 compare width.
  assign unused_rem = rem_q[8];

`ifdef DIV_ROUND_EN
  logic [24:0] rnd_sum;
  assign rnd_sum = {1'b0, quo_q[24:1]} + {24'd0, quo_q[0]};
  assign res24   = rnd_sum[24] ? 24'hFFFFFF : rnd_sum[23:0];
`else
  assign res24 = quo_q;
`endif

  always_comb begin
    state_d = state_q;
    armed_d = armed_q;
    ack_d   = ack_q;
    dvd_d   = dvd_q;
    dvs_d   = dvs_q;
    rem_d   = rem_q;
    quo_d   = quo_q;
    cnt_d   = cnt_q;
    case (state_q)
      StIdle, StDone: begin
        if (Start) begin
          armed_d = 1'b1;
          if (state_q == StDone) ack_d = 1'b0;
        end else if (armed_q) begin
          armed_d = 1'b0;
          state_d = StRdHi;
        end
      end
      StRdHi: begin
        dvd_d[15:8] = MemRdData;
        state_d     = StRdLo;
      end
      StRdLo: begin
        dvd_d[7:0] = MemRdData;
        state_d    = StRdDvs;
      end
      StRdDvs: begin
        dvs_d = MemRdData;
        rem_d = '0;
        if (MemRdData == 8'd0) begin
          quo_d   = '1;
          state_d = StWr0;
        end else begin
          quo_d   = '0;
          cnt_d   = 5'(QW - 1);
          state_d = StDiv;
        end
      end
      StDiv: begin
        rem_d = q_bit ? (r9 - {1'b0, dvs_q}) : r9;
        quo_d = {quo_q[QW-2:0], q_bit};
        if (cnt_q == 5'd0) begin
          state_d = StWr0;
        end else begin
          cnt_d = cnt_q - 5'd1;
        end
      end
      StWr0: state_d = StWr1;
      StWr1: state_d = StWr2;
      StWr2: begin
        state_d = StDone;
        ack_d   = 1'b1;
      end
      default: state_d = StIdle;
    endcase
  end

  always_ff @(posedge Clk) begin
    if (!Reset) begin
      state_q <= StIdle;
      armed_q <= 1'b0;
      ack_q   <= 1'b0;
      dvd_q   <= '0;
      dvs_q   <= '0;
      rem_q   <= '0;
      quo_q   <= '0;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      armed_q <= armed_d;
      ack_q   <= ack_d;
      dvd_q   <= dvd_d;
      dvs_q   <= dvs_d;
      rem_q   <= rem_d;
      quo_q   <= quo_d;
      cnt_q   <= cnt_d;
    end
  end

  // Address and write data are decoded from the state so reads and writes never overlap.
  always_comb begin
    MemAddr   = '0;
    MemWrData = 8'd0;
    MemWrEn   = 1'b0;
    case (state_q)
      StRdHi:  MemAddr = AW'(A_DVD_HI);
      StRdLo:  MemAddr = AW'(A_DVD_LO);
      StRdDvs: MemAddr = AW'(A_DVS);
      StWr0: begin
        MemAddr   = AW'(A_Q);
        MemWrData = res24[23:16];
        MemWrEn   = 1'b1;
      end
      StWr1: begin
        MemAddr   = AW'(A_Q + 1);
        MemWrData = res24[15:8];
        MemWrEn   = 1'b1;
      end
      StWr2: begin
        MemAddr   = AW'(A_Q + 2);
        MemWrData = res24[7:0];
        MemWrEn   = 1'b1;
      end
      default: ;
    endcase
  end

  assign Ack  = ack_q;
  assign Busy = (state_q != StIdle) && (state_q != StDone);

endmodule

// File: tb/tb_div_fx_engine.sv
module tb_div_fx_engine;

  logic       Clk = 1'b0;
  logic       Reset;
  logic       Start;
  logic       Ack;
  logic       Busy;
  logic [7:0] MemAddr;
  logic [7:0] MemRdData;
  logic       MemWrEn;
  logic [7:0] MemWrData;

  logic [7:0] mem [0:255];
  logic [7:0] log_addr [0:1023];
  logic [7:0] log_data [0:1023];
  int wr_count = 0;

  int errors = 0;
  int checks = 0;

  div_fx_engine dut (
    .Clk       (Clk),
    .Reset     (Reset),
    .Start     (Start),
    .Ack       (Ack),
    .Busy      (Busy),
    .MemAddr   (MemAddr),
    .MemRdData (MemRdData),
    .MemWrEn   (MemWrEn),
    .MemWrData (MemWrData)
  );

  always #5 Clk = ~Clk;

  assign MemRdData = mem[MemAddr];

  // Log every byte the DUT writes; only this process touches the log.
  always @(posedge Clk) begin
    if (MemWrEn) begin
      log_addr[wr_count & 1023] <= MemAddr;
      log_data[wr_count & 1023] <= MemWrData;
      wr_count <= wr_count + 1;
    end
  end

  // Reference quotient straight from the arithmetic definition.
  function automatic logic [23:0] model_q(input logic [15:0] dvd, input logic [7:0] dvs);
    longint unsigned q;
    if (dvs == 8'd0) return 24'hFFFFFF;
`ifdef DIV_ROUND_EN
    q = ((longint'(dvd) * 512) / longint'(dvs) + 1) / 2;
    if (q > 64'hFFFFFF) q = 64'hFFFFFF;
`else
    q = (longint'(dvd) * 256) / longint'(dvs);
`endif
    return q[23:0];
  endfunction

  function automatic int model_lat(input logic [7:0] dvs);
    if (dvs == 8'd0) return 7;
`ifdef DIV_ROUND_EN
    return 32;
`else
    return 31;
`endif
  endfunction

  // Launches one run and collects what it did; callers do their own comparisons.
  task automatic do_run(input logic [15:0] dvd, input logic [7:0] dvs, input bit pulse_mid,
                        output int edges, output bit busy_at_ack, output int nwr,
                        output logic [23:0] addrs, output logic [23:0] bytes_o);
    int base;
    int n;
    bit done;
    base = wr_count;
    @(negedge Clk);
    mem[0] = dvd[15:8];
    mem[1] = dvd[7:0];
    mem[2] = dvs;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    n = 0;
    done = 1'b0;
    edges = -1;
    busy_at_ack = 1'b1;
    while (!done && n < 80) begin
      @(posedge Clk);
      #1;
      n++;
      if (n == 5) begin
        // Operands already consumed; changing them must not matter.
        mem[0] = 8'($urandom);
        mem[1] = 8'($urandom);
        mem[2] = 8'($urandom);
      end
      if (pulse_mid && n == 6) Start = 1'b1;
      if (pulse_mid && n == 9) Start = 1'b0;
      if (Ack) begin
        done = 1'b1;
        edges = n;
        busy_at_ack = Busy;
      end
    end
    Start = 1'b0;
    nwr = wr_count - base;
    addrs = {log_addr[base & 1023], log_addr[(base + 1) & 1023], log_addr[(base + 2) & 1023]};
    bytes_o = {log_data[base & 1023], log_data[(base + 1) & 1023], log_data[(base + 2) & 1023]};
  endtask

  task automatic test_reset();
    Reset = 1'b0;
    Start = 1'b0;
    repeat (2) @(posedge Clk);
    #1;
    checks += 5;
    if (Ack !== 1'b0) begin errors++; $display("FAIL reset_ack got=%b exp=0", Ack); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL reset_busy got=%b exp=0", Busy); end
    if (MemWrEn !== 1'b0) begin errors++; $display("FAIL reset_wren got=%b exp=0", MemWrEn); end
    if (MemAddr !== 8'd0) begin errors++; $display("FAIL reset_addr got=%h exp=00", MemAddr); end
    if (MemWrData !== 8'd0) begin
      errors++; $display("FAIL reset_wdata got=%h exp=00", MemWrData);
    end
    @(negedge Clk);
    Reset = 1'b1;
  endtask

  task automatic test_vectors();
    logic [15:0] dv [5] = '{16'd12800, 16'd3, 16'd2, 16'd65535, 16'd1234};
    logic [7:0]  ds [5] = '{8'd25, 8'd255, 8'd3, 8'd1, 8'd0};
    int edges, nwr;
    bit busy;
    logic [23:0] a, b;
    for (int i = 0; i < 5; i++) begin
      do_run(dv[i], ds[i], 1'b0, edges, busy, nwr, a, b);
      checks += 5;
      if (edges != model_lat(ds[i])) begin
        errors++; $display("FAIL vec%0d_latency got=%0d exp=%0d", i, edges, model_lat(ds[i]));
      end
      if (busy !== 1'b0) begin errors++; $display("FAIL vec%0d_busy_at_ack got=%b exp=0", i, busy); end
      if (nwr != 3) begin errors++; $display("FAIL vec%0d_nwrites got=%0d exp=3", i, nwr); end
      if (a !== 24'h040506) begin errors++; $display("FAIL vec%0d_addrs got=%h exp=040506", i, a); end
      if (b !== model_q(dv[i], ds[i])) begin
        errors++; $display("FAIL vec%0d_quot got=%h exp=%h", i, b, model_q(dv[i], ds[i]));
      end
    end
  endtask

  task automatic test_random();
    logic [15:0] dvd;
    logic [7:0] dvs;
    int edges, nwr;
    bit busy;
    logic [23:0] a, b;
    for (int i = 0; i < 20; i++) begin
      dvd = 16'($urandom);
      dvs = ($urandom_range(0, 7) == 0) ? 8'd0 : 8'($urandom_range(1, 255));
      do_run(dvd, dvs, 1'b0, edges, busy, nwr, a, b);
      checks += 3;
      if (edges != model_lat(dvs)) begin
        errors++; $display("FAIL rnd_latency D=%0d d=%0d got=%0d exp=%0d", dvd, dvs, edges,
                           model_lat(dvs));
      end
      if (nwr != 3 || a !== 24'h040506) begin
        errors++; $display("FAIL rnd_writes D=%0d d=%0d got=%0d@%h exp=3@040506", dvd, dvs, nwr, a);
      end
      if (b !== model_q(dvd, dvs)) begin
        errors++; $display("FAIL rnd_quot D=%0d d=%0d got=%h exp=%h", dvd, dvs, b, model_q(dvd, dvs));
      end
    end
  endtask

  task automatic test_reset_mid_div();
    int base, edges, nwr;
    bit busy;
    logic [23:0] a, b;
    @(negedge Clk);
    mem[0] = 8'h32;
    mem[1] = 8'h00;
    mem[2] = 8'd25;
    Start = 1'b1;
    @(negedge Clk);
    Start = 1'b0;
    repeat (10) @(posedge Clk);
    @(negedge Clk);
    Reset = 1'b0;
    base = wr_count;
    @(posedge Clk);
    #1;
    checks += 3;
    if (Ack !== 1'b0) begin errors++; $display("FAIL midrst_ack got=%b exp=0", Ack); end
    if (Busy !== 1'b0) begin errors++; $display("FAIL midrst_busy got=%b exp=0", Busy); end
    if (MemWrEn !== 1'b0) begin errors++; $display("FAIL midrst_wren got=%b exp=0", MemWrEn); end
    @(negedge Clk);
    Reset = 1'b1;
    repeat (40) @(posedge Clk);
    #1;
    checks += 2;
    if (wr_count != base) begin
      errors++; $display("FAIL midrst_nowrite got=%0d exp=0", wr_count - base);
    end
    if (Ack !== 1'b0) begin errors++; $display("FAIL midrst_ack_idle got=%b exp=0", Ack); end
    do_run(16'd12800, 8'd25, 1'b0, edges, busy, nwr, a, b);
    checks += 2;
    if (nwr != 3) begin errors++; $display("FAIL midrst_rerun_nwr got=%0d exp=3", nwr); end
    if (b !== 24'h020000) begin errors++; $display("FAIL midrst_rerun_quot got=%h exp=020000", b); end
  endtask

  task automatic test_back_to_back();
    int base, edges, nwr;
    bit busy;
    logic [23:0] a, b;
    base = wr_count;
    do_run(16'd40000, 8'd7, 1'b1, edges, busy, nwr, a, b);
    checks += 2;
    if (edges != model_lat(8'd7)) begin
      errors++; $display("FAIL b2b_latency got=%0d exp=%0d", edges, model_lat(8'd7));
    end
    if (b !== model_q(16'd40000, 8'd7)) begin
      errors++; $display("FAIL b2b_quot got=%h exp=%h", b, model_q(16'd40000, 8'd7));
    end
    repeat (40) @(posedge Clk);
    #1;
    checks += 2;
    if (wr_count - base != 3) begin
      errors++; $display("FAIL b2b_no_relaunch got=%0d exp=3", wr_count - base);
    end
    if (Ack !== 1'b1) begin errors++; $display("FAIL b2b_ack_held got=%b exp=1", Ack); end
    @(negedge Clk);
    Start = 1'b1;
    @(posedge Clk);
    #1;
    checks += 1;
    if (Ack !== 1'b0) begin errors++; $display("FAIL b2b_ack_drop got=%b exp=0", Ack); end
    do_run(16'd1000, 8'd9, 1'b0, edges, busy, nwr, a, b);
    checks += 3;
    if (edges != model_lat(8'd9)) begin
      errors++; $display("FAIL b2b2_latency got=%0d exp=%0d", edges, model_lat(8'd9));
    end
    if (nwr != 3) begin errors++; $display("FAIL b2b2_nwr got=%0d exp=3", nwr); end
    if (b !== model_q(16'd1000, 8'd9)) begin
      errors++; $display("FAIL b2b2_quot got=%h exp=%h", b, model_q(16'd1000, 8'd9));
    end
  endtask

  initial begin
    for (int i = 0; i < 256; i++) mem[i] = 8'h5A;
    test_reset();
    test_vectors();
    test_random();
    test_reset_mid_div();
    test_back_to_back();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
